// File: rtl/gray_rx_checker.sv
// Receive-side gray-code stream checker: decodes each sample and verifies
// single-step +1 progression, with error pulses, error count and lock.
module gray_rx_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             gray_valid,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             seq_err,
    output logic             hd_err,
    output logic             wrap_pulse,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] LOCK_MAX = GW'(LOCK_CNT);

    typedef enum logic [1:0] {
        S_ACQ,
        S_TRACK,
        S_LOCK
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic [WIDTH-1:0] prev_bin_q, prev_bin_d;
    logic [GW-1:0]    good_cnt_q, good_cnt_d;
    logic             seed_rep_q, seed_rep_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             bin_valid_q, bin_valid_d;
    logic             seq_err_q, seq_err_d;
    logic             hd_err_q, hd_err_d;
    logic             wrap_q, wrap_d;
    logic             locked_q, locked_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] next_bin;
    logic [GW-1:0]    cnt_inc;
    logic             one_bit;
    logic             in_seq;
    logic             absorb;

    // Each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec[i] = ^(gray_in >> i);
        end
    end

    assign diff     = gray_in ^ prev_gray_q;
    assign one_bit  = (diff != '0) && ((diff & (diff - 1'b1)) == '0);
    assign next_bin = prev_bin_q + 1'b1;
    assign in_seq   = (dec == next_bin);
    assign absorb   = seed_rep_q && (gray_in == prev_gray_q);
    assign cnt_inc  = good_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ACQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (gray_valid) begin
            unique case (state_q)
                S_ACQ: state_d = S_TRACK;
                S_TRACK: begin
                    if (!absorb && in_seq && cnt_inc == LOCK_MAX) begin
                        state_d = S_LOCK;
                    end
                end
                S_LOCK: begin
                    if (!absorb && !in_seq) begin
                        state_d = S_TRACK;
                    end
                end
                default: state_d = S_ACQ;
            endcase
        end
    end

    always_comb begin
        prev_gray_d = prev_gray_q;
        prev_bin_d  = prev_bin_q;
        good_cnt_d  = good_cnt_q;
        seed_rep_d  = seed_rep_q;
        bin_d       = bin_q;
        bin_valid_d = 1'b0;
        seq_err_d   = 1'b0;
        hd_err_d    = 1'b0;
        wrap_d      = 1'b0;
        err_cnt_d   = err_cnt_q;
        locked_d    = (state_d == S_LOCK);
        if (gray_valid) begin
            prev_gray_d = gray_in;
            prev_bin_d  = dec;
            bin_d       = dec;
            bin_valid_d = 1'b1;
            seed_rep_d  = 1'b0;
            if (state_q == S_ACQ) begin
                seed_rep_d = 1'b1;
                good_cnt_d = '0;
            end else if (absorb) begin
                good_cnt_d = good_cnt_q;
            end else if (in_seq) begin
                if (good_cnt_q != LOCK_MAX) begin
                    good_cnt_d = cnt_inc;
                end
                wrap_d = (prev_bin_q == '1) && (dec == '0);
            end else begin
                seq_err_d  = 1'b1;
                hd_err_d   = !one_bit;
                good_cnt_d = '0;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray_q <= '0;
            prev_bin_q  <= '0;
            good_cnt_q  <= '0;
            seed_rep_q  <= 1'b0;
            bin_q       <= '0;
            bin_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
            hd_err_q    <= 1'b0;
            wrap_q      <= 1'b0;
            locked_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            prev_gray_q <= prev_gray_d;
            prev_bin_q  <= prev_bin_d;
            good_cnt_q  <= good_cnt_d;
            seed_rep_q  <= seed_rep_d;
            bin_q       <= bin_d;
            bin_valid_q <= bin_valid_d;
            seq_err_q   <= seq_err_d;
            hd_err_q    <= hd_err_d;
            wrap_q      <= wrap_d;
            locked_q    <= locked_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bin_out    = bin_q;
    assign bin_valid  = bin_valid_q;
    assign seq_err    = seq_err_q;
    assign hd_err     = hd_err_q;
    assign wrap_pulse = wrap_q;
    assign locked     = locked_q;
    assign err_count  = err_cnt_q;

endmodule

// File: doc/gray_rx_checker.md
# gray_rx_checker

Receive-side companion to the team's gray-code counter. Samples a gray-coded count stream, decodes each sample to binary, and checks that consecutive samples advance by exactly one step (single-bit change, +1 modulo 2^WIDTH). It exposes the decoded value, per-sample error pulses, a saturating error counter and a lock indicator. It sits at the consuming end of any gray-coded count link, such as a clock-domain pointer or a status counter.

## Interface
- WIDTH, 4, gray/binary width (≥2)
- LOCK_CNT, 4, consecutive in-sequence samples required to assert locked (≥1)
- ERR_W, 8, width of err_count

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- gray_in  in  WIDTH  gray-coded sample
- gray_valid  in  1  gray_in is a sample this cycle
- bin_out  out  WIDTH  decoded binary of last accepted sample
- bin_valid  out  1  one-cycle pulse: bin_out and error flags updated
- seq_err  out  1  pulse: sample is not prev+1 (mod 2^WIDTH)
- hd_err  out  1  pulse: sample differs from previous gray in ≠1 bit
- wrap_pulse  out  1  pulse: in-sequence step from all-ones to 0
- locked  out  1  level: stream in sequence for ≥ LOCK_CNT steps
- err_count  out  ERR_W  count of seq_err events, saturating at 2^ERR_W−1

## Operation
- Decode: bin[WIDTH−1]=g[WIDTH−1]; bin[i]=bin[i+1]^g[i], purely combinational before the output register.
- Stored state: prev_gray, prev_bin, good_cnt (saturates at LOCK_CNT), seed_rep flag, FSM.
- FSM states: ACQUIRE, TRACK, LOCKED.
  - ACQUIRE: first valid sample seeds prev_gray/prev_bin, emits bin_valid, raises no errors, sets seed_rep=1, and moves to TRACK with good_cnt=0.
  - TRACK, sample in sequence: good_cnt+1. When good_cnt reaches LOCK_CNT, go to LOCKED.
  - TRACK, sample out of sequence: raise errors, set good_cnt=0, stay in TRACK.
  - LOCKED, sample out of sequence: raise errors, go to TRACK, set good_cnt=0.
- Seed repeat: the upstream counter emits its reset value twice. Therefore the first valid sample after seeding that equals the seed is absorbed silently: bin_valid=1, no error, good_cnt unchanged, seed_rep cleared. Any other sample also clears seed_rep.
- Every accepted sample, good or bad, overwrites prev_gray/prev_bin. The checker resynchronises to the received stream.
- hd_err = popcount(gray_in ^ prev_gray) ≠ 1.
- seq_err = decoded ≠ prev_bin+1 (WIDTH-bit wrap). hd_err implies seq_err; a backward or repeated single-bit step gives seq_err only.
- err_count increments on each seq_err and holds at its maximum value.
- gray_valid low: no state change; all pulses low.

## Timing
- Latency is one cycle: a sample accepted at edge N drives bin_out, bin_valid, seq_err, hd_err and wrap_pulse after edge N. These pulses last exactly one cycle.
- locked and err_count update on the same edge as the triggering sample's flags.
- Back-to-back valid samples are accepted every cycle. Gaps of any length are allowed.
- Reset values: bin_out=0, bin_valid=0, seq_err=0, hd_err=0, wrap_pulse=0, locked=0, err_count=0. Internal state: FSM=ACQUIRE, good_cnt=0, seed_rep=0.
- rst has priority over gray_valid in the same cycle. Reset mid-stream discards history, and the next valid sample reseeds.
- Wrap: prev_bin=2^WIDTH−1 followed by decoded 0 is in sequence. It pulses wrap_pulse and raises no error.

## Test plan
- Reset, then feed gray 0,0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0 back-to-back. Expected response:
  - bin_out reads 0,0,1,…,15,0, one cycle after each sample.
  - No error pulses.
  - locked rises with the 6th sample's bin_valid.
  - wrap_pulse fires with the final 0.
  - err_count=0.
- While locked at gray 3 (bin 2), feed gray 6 (bin 4). Expected: seq_err=1, hd_err=1, err_count=1, locked=0 on the same edge. Then feed gray 7 (bin 5): no error, and locked returns after 4 further good steps.
- From gray 7 (bin 5), feed gray 6 (bin 4). Expected: seq_err=1, hd_err=0, err_count increments.
- Interleave 3 idle cycles between each sample of a valid sequence. Expected: bin_valid pulses only on sample cycles, no errors, and lock timing is counted in samples rather than cycles.
- With ERR_W=2, feed 5 out-of-sequence samples after seeding. Expected: err_count reads 1,2,3,3,3.
- Assert rst for one cycle while locked, with gray_valid=1 in that same cycle. Expected: all outputs 0 on the next cycle. The following valid sample reseeds with no error, and a value of 9 seeds bin_out=14.
